// File: rtl/riscv_decode.sv
// riscv_decode -- RV32I instruction decode stage.
//
// Accepts one {pc, instruction} word per upstream handshake, decodes it into
// register indices, a sign-extended immediate, an ALU operation and one-hot
// class flags, and presents the result to execute through a registered
// output register (OR) backed by a one-entry skid register (SK). f_ready is a
// flop, so it never depends combinationally on x_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous kill of every held entry (branch redirect)
//   f_valid    fetch presents an instruction
//   f_ready    decode can accept (registered)
//   f_pc       pc of the presented instruction
//   f_instr    presented instruction word
//   d_valid    decoded entry valid toward execute
//   x_ready    execute accepts
//   d_pc       pc of the decoded entry
//   d_rs1/rs2/rd  register indices, 0 when the format does not use them
//   d_imm      sign-extended immediate
//   d_alu_op   0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 PASSB
//   d_funct3   raw instr[14:12]
//   d_cls      {op, op_imm, lui, auipc, jal, jalr, branch, load, store}
//   d_illegal  word is not a legal RV32I base instruction
module riscv_decode #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 f_valid,
  output logic                 f_ready,
  input  logic [BUS_WIDTH-1:0] f_pc,
  input  logic [BUS_WIDTH-1:0] f_instr,
  output logic                 d_valid,
  input  logic                 x_ready,
  output logic [BUS_WIDTH-1:0] d_pc,
  output logic [4:0]           d_rs1,
  output logic [4:0]           d_rs2,
  output logic [4:0]           d_rd,
  output logic [31:0]          d_imm,
  output logic [3:0]           d_alu_op,
  output logic [2:0]           d_funct3,
  output logic [8:0]           d_cls,
  output logic                 d_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // Packed in d_cls bit order: slice gi holds the opcode for class bit gi.
  localparam logic [62:0] CLS_OPCODES = {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                                         OPC_JAL, OPC_JALR, OPC_BRANCH,
                                         OPC_LOAD, OPC_STORE};

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [3:0]           alu_op;
    logic [2:0]           funct3;
    logic [8:0]           cls;
    logic                 illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [31:0] instr;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [8:0]  cls_hit;
  logic        is_op, is_op_imm, is_lui, is_auipc, is_jal, is_jalr;
  logic        is_branch, is_load, is_store;
  logic        bad_op, bad_shift, illegal;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  alu_base;
  entry_t      dec;

  assign instr  = f_instr[31:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cls
      assign cls_hit[gi] = (instr[6:0] == CLS_OPCODES[gi*7 +: 7]);
    end
  endgenerate

  assign is_op     = cls_hit[8];
  assign is_op_imm = cls_hit[7];
  assign is_lui    = cls_hit[6];
  assign is_auipc  = cls_hit[5];
  assign is_jal    = cls_hit[4];
  assign is_jalr   = cls_hit[3];
  assign is_branch = cls_hit[2];
  assign is_load   = cls_hit[1];
  assign is_store  = cls_hit[0];

  // Register-register ops only allow funct7 0x00, or 0x20 on ADD/SRL slots.
  assign bad_op = is_op &&
                  ((funct7 != 7'h00 && funct7 != 7'h20) ||
                   (funct7 == 7'h20 && funct3 != 3'd0 && funct3 != 3'd5));
  // Immediate shifts carry a funct7 in the upper immediate bits.
  assign bad_shift = is_op_imm &&
                     ((funct3 == 3'd1 && funct7 != 7'h00) ||
                      (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20));
  assign illegal = (instr[1:0] != 2'b11) || (cls_hit == 9'd0) || bad_op || bad_shift;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    alu_base = ALU_ADD;
    case (funct3)
      3'd0: alu_base = ALU_ADD;
      3'd1: alu_base = ALU_SLL;
      3'd2: alu_base = ALU_SLT;
      3'd3: alu_base = ALU_SLTU;
      3'd4: alu_base = ALU_XOR;
      3'd5: alu_base = ALU_SRL;
      3'd6: alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  end

  // Illegal words keep their pc (a trap needs it) but every decoded field is 0.
  always_comb begin
    dec         = '0;
    dec.pc      = f_pc;
    dec.illegal = illegal;
    if (!illegal) begin
      dec.cls    = cls_hit;
      dec.funct3 = funct3;
      if (is_op || is_op_imm || is_jalr || is_branch || is_load || is_store)
        dec.rs1 = instr[19:15];
      if (is_op || is_branch || is_store)
        dec.rs2 = instr[24:20];
      if (!(is_branch || is_store))
        dec.rd = instr[11:7];

      if (is_op_imm || is_jalr || is_load) dec.imm = imm_i;
      else if (is_store)                   dec.imm = imm_s;
      else if (is_branch)                  dec.imm = imm_b;
      else if (is_lui || is_auipc)         dec.imm = imm_u;
      else if (is_jal)                     dec.imm = imm_j;

      // funct7 is already known to be 0x00/0x20 here, so bit 5 is enough.
      if (is_op) begin
        if (funct3 == 3'd0 && funct7[5])      dec.alu_op = ALU_SUB;
        else if (funct3 == 3'd5 && funct7[5]) dec.alu_op = ALU_SRA;
        else                                  dec.alu_op = alu_base;
      end else if (is_op_imm) begin
        if (funct3 == 3'd5 && instr[30])      dec.alu_op = ALU_SRA;
        else                                  dec.alu_op = alu_base;
      end else if (is_lui) begin
        dec.alu_op = ALU_PASSB;
      end else begin
        dec.alu_op = ALU_ADD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register + skid register
  // ---------------------------------------------------------------------------
  entry_t or_data_reg, sk_data_reg;
  logic   or_valid_reg, sk_valid_reg;
  logic   f_ready_reg;
  logic   accept, drain, or_free;
  logic   sk_valid_next;

  assign accept  = f_valid && f_ready_reg;
  assign drain   = or_valid_reg && x_ready;
  assign or_free = !or_valid_reg || drain;

  // SK only stays/becomes occupied when OR cannot take the next entry.
  always_comb begin
    if (flush)        sk_valid_next = 1'b0;
    else if (or_free) sk_valid_next = sk_valid_reg && accept;
    else              sk_valid_next = sk_valid_reg || accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      or_valid_reg <= 1'b0;
      sk_valid_reg <= 1'b0;
      f_ready_reg  <= 1'b1;
      or_data_reg  <= '0;
      sk_data_reg  <= '0;
    end else begin
      sk_valid_reg <= sk_valid_next;
      f_ready_reg  <= !sk_valid_next;
      if (flush) begin
        or_valid_reg <= 1'b0;
      end else begin
        if (or_free) begin
          // SK is older than anything arriving now, so it always wins OR.
          if (sk_valid_reg) begin
            or_data_reg  <= sk_data_reg;
            or_valid_reg <= 1'b1;
          end else if (accept) begin
            or_data_reg  <= dec;
            or_valid_reg <= 1'b1;
          end else begin
            or_valid_reg <= 1'b0;
          end
        end
        if (accept && (sk_valid_reg || !or_free))
          sk_data_reg <= dec;
      end
    end
  end

  assign f_ready   = f_ready_reg;
  assign d_valid   = or_valid_reg;
  assign d_pc      = or_data_reg.pc;
  assign d_rs1     = or_data_reg.rs1;
  assign d_rs2     = or_data_reg.rs2;
  assign d_rd      = or_data_reg.rd;
  assign d_imm     = or_data_reg.imm;
  assign d_alu_op  = or_data_reg.alu_op;
  assign d_funct3  = or_data_reg.funct3;
  assign d_cls     = or_data_reg.cls;
  assign d_illegal = or_data_reg.illegal;

endmodule

// File: doc/riscv_decode.md
# riscv_decode

Instruction decode stage of the RV32I core. Sits directly downstream of the fetch block and accepts one {pc, instruction} word per handshake. Splits each word into register indices, a sign-extended immediate, an ALU operation code and class flags. Presents the result to execute through a registered valid/ready interface with a one-entry skid buffer, so `f_ready` never depends combinationally on `x_ready`.

## Interface

Parameters:
- `BUS_WIDTH`, 32: pc and instruction width. Only 32 is supported.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `flush`  in  1  Synchronous kill of all held instructions (branch redirect).
- `f_valid`  in  1  Fetch presents an instruction.
- `f_ready`  out  1  Decode can accept. Registered.
- `f_pc`  in  32  PC of the presented instruction.
- `f_instr`  in  32  Presented instruction word.
- `d_valid`  out  1  Decoded instruction valid toward execute.
- `x_ready`  in  1  Execute accepts.
- `d_pc`  out  32  PC of the decoded instruction.
- `d_rs1`, `d_rs2`, `d_rd`  out  5 each  Register indices. Forced to 0 when unused by the format.
- `d_imm`  out  32  Sign-extended immediate.
- `d_alu_op`  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `d_funct3`  out  3  Raw `instr[14:12]`.
- `d_cls`  out  9  One-hot class flags: {op, op_imm, lui, auipc, jal, jalr, branch, load, store}. Bit 8 = op.
- `d_illegal`  out  1  Instruction is not a legal RV32I base instruction.

## Operation

- **Upstream transfer**: occurs when `f_valid & f_ready`. **Downstream transfer**: occurs when `d_valid & x_ready`.
- **Storage**: output register (OR) plus skid register (SK), each with its own valid bit. Decode logic runs on `f_instr` before the value is captured, so both OR and SK hold fully decoded fields.
- **Accept, OR empty or draining this cycle**: the new entry goes to OR, or to OR from SK if SK is valid, which preserves order.
- **Accept, OR full and not draining**: the new entry goes to SK.
- **`f_ready`**: next value is `!SK_valid_next`.
- **Drain with SK valid**: SK moves to OR and SK is cleared.
- **Immediates**:
  - I: `{{20{i[31]}}, i[31:20]}`
  - S: `{{20{i[31]}}, i[31:25], i[11:7]}`
  - B: `{{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}`
  - U: `{i[31:12], 12'b0}`
  - J: `{{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}`
- **ALU op selection**:
  - OP: funct3 selects the op. funct7 = 0x20 selects SUB for funct3 0 and SRA for funct3 5.
  - OP_IMM: same mapping, but SUB is never selected; SRAI is taken from `i[30]`.
  - LUI: PASSB.
  - All other classes: ADD.
- **Illegal**: `i[1:0] != 2'b11`, unknown opcode, OP with funct7 not in {0x00, 0x20}, funct7 = 0x20 with funct3 not in {0, 5}, or OP_IMM shift with a bad funct7.
  - Illegal entries still flow, with `d_illegal = 1`, `d_cls = 0`, ADD, and all fields 0.
- **Flush**: OR_valid and SK_valid are cleared next cycle and `f_ready` is 1 next cycle. An input accepted in the flush cycle is discarded. Flush overrides both transfers.

## Timing

- **Reset** (asynchronous, while `reset` = 0): `d_valid` = 0, `f_ready` = 1, SK_valid = 0, all data outputs 0.
- **Latency**: 1 cycle from accept to `d_valid`.
- **Throughput**: 1 instruction/cycle with `x_ready` held high.
- **Stall**: after `x_ready` falls, at most one further instruction is accepted (into SK). `f_ready` drops the following cycle.
- **Output stability**: while `d_valid & !x_ready`, all `d_*` outputs hold stable.
- **Simultaneous accept and drain with SK valid**: SK goes to OR and the input goes to SK. `f_ready` stays 0.
- **Reset asserted mid-stall**: all held entries are lost and no output glitch beyond the asynchronous clear.

## Test plan

- **ADDI**: `0xFFF00093` (addi x1, x0, -1) with `x_ready` = 1 → next cycle `d_valid` = 1, rd = 1, rs1 = 0, imm = `0xFFFFFFFF`, alu = ADD, cls = op_imm.
- **Format mix**:
  - `0x0020A423` (sw x2, 8(x1)) → imm 8, rs1 1, rs2 2, rd 0, store.
  - `0xFE000EE3` (beq x0, x0, -4) → imm `0xFFFFFFFC`, branch.
  - `0x123452B7` (lui x5, 0x12345) → imm `0x12345000`, rd 5, rs1 0, PASSB.
- **Backpressure**: stream PCs 0, 4, 8, 12 with `f_valid` = 1 and hold `x_ready` = 0 for 3 cycles → `f_ready` = 0 from the cycle after the second accept. On release, execute sees 0, 4, 8, 12 in order with no loss and no duplication.
- **Flush**: with OR and SK both full, pulse `flush` → next cycle `d_valid` = 0, `f_ready` = 1. The next accepted instruction emerges alone after 1 cycle.
- **Illegal**:
  - `0x00000000` → `d_illegal` = 1, `d_cls` = 0.
  - `0x40001033` (funct7 0x20, funct3 1) → `d_illegal` = 1.
  - `0x40000033` (sub x0, x0, x0) → SUB, not illegal.
- **Reset mid-stall**: assert `reset` low mid-cycle with SK full → `d_valid` and SK_valid drop immediately and `f_ready` = 1. After release, the first accepted instruction decodes correctly.
